// File: rtl/dot_sched_pkg.sv
// ---------------------------------------------------------------------------
// dot_sched_pkg
// Shared definitions for the dot-engine sequencer: engine word geometry
// (rows x channels x data length), the dot address/cs widths and the
// sequencer state encoding.
// No ports (package).
// ---------------------------------------------------------------------------
package dot_sched_pkg;

    // Width of one data word produced by the dot engine.
    localparam int DATA_LEN = 16;
    // Result geometry: DOT_ROWS beats of DOT_CH words each.
    localparam int DOT_ROWS = 12;
    localparam int DOT_CH   = 32;
    localparam int WORD_W   = DOT_CH * DATA_LEN;
    localparam int Q_W      = DOT_ROWS * WORD_W;
    // Engine-local fetch address and channel-select widths.
    localparam int DOT_AW   = 9;
    localparam int CS_W     = 4;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_WB   = 3'd2,
        ST_GAP  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

endpackage

// File: rtl/dot_wb_slicer.sv
// ---------------------------------------------------------------------------
// dot_wb_slicer
// Combinational beat-to-slice mux: picks row `beat_i` of the dot result
// bus so it can be written to the result RAM as one wide word.
// Ports:
//   dot_q_i   in  ROWS*WORD_W  full dot result bus
//   beat_i    in  BEAT_W       row index to forward
//   wb_data_o out WORD_W       selected row (0 for out-of-range index)
// ---------------------------------------------------------------------------
module dot_wb_slicer
    import dot_sched_pkg::*;
#(
    parameter int ROWS   = DOT_ROWS,
    parameter int BEAT_W = 4
) (
    input  logic [ROWS*WORD_W-1:0] dot_q_i,
    input  logic [BEAT_W-1:0]      beat_i,
    output logic [WORD_W-1:0]      wb_data_o
);

    // Explicit compare-per-row mux keeps an out-of-range beat from indexing
    // past the end of the bus.
    always_comb begin
        wb_data_o = '0;
        for (int i = 0; i < ROWS; i++) begin
            if (beat_i == BEAT_W'(i)) begin
                wb_data_o = dot_q_i[i*WORD_W +: WORD_W];
            end
        end
    end

endmodule

// File: rtl/dot_sched.sv
// ---------------------------------------------------------------------------
// dot_sched
// Sequencer for the 32-channel dot engine. A start runs one dot pass per
// channel select cs = 0..last_cs: hold load high until the engine reports
// valid, stream the WB_BEATS result rows to the result RAM, then drop load
// for GAP_CYC cycles so the engine re-initialises on the next pass.
// Ports:
//   clk, rst    clock (rising edge) and asynchronous active-high reset
//   start       1-cycle run request, ignored while busy
//   abort       synchronous cancel, overrides every transition
//   last_cs     final cs of the run (latched on accepted start)
//   rd_base     feature-RAM base address (latched on accepted start)
//   wb_base     result-RAM base address (latched on accepted start)
//   busy        high in LOAD / WB / GAP
//   done        1-cycle completion pulse
//   err         sticky load timeout flag, cleared by the next start
//   dot_load    dot engine load
//   dot_cs      dot engine channel select
//   dot_addr    dot engine fetch address (engine-local)
//   dot_valid   dot engine result valid
//   dot_q       dot engine result bus
//   rd_addr     feature-RAM address = rd_base + cs*RD_STRIDE + dot_addr
//   wb_en       result-RAM write strobe
//   wb_addr     result-RAM address = wb_base + cs*WB_BEATS + beat
//   wb_data     result-RAM write data (one result row)
// ---------------------------------------------------------------------------
module dot_sched
    import dot_sched_pkg::*;
#(
    parameter int RD_AW     = 12,
    parameter int WB_AW     = 10,
    parameter int RD_STRIDE = 512,
    parameter int WB_BEATS  = 12,
    parameter int GAP_CYC   = 2,
    parameter int TIMEOUT   = 4095
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [CS_W-1:0]      last_cs,
    input  logic [RD_AW-1:0]     rd_base,
    input  logic [WB_AW-1:0]     wb_base,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic                 dot_load,
    output logic [CS_W-1:0]      dot_cs,
    input  logic [DOT_AW-1:0]    dot_addr,
    input  logic                 dot_valid,
    input  logic [Q_W-1:0]       dot_q,
    output logic [RD_AW-1:0]     rd_addr,
    output logic                 wb_en,
    output logic [WB_AW-1:0]     wb_addr,
    output logic [WORD_W-1:0]    wb_data
);

    localparam int BEAT_W = (WB_BEATS > 1) ? $clog2(WB_BEATS) : 1;
    localparam int TMR_W  = $clog2(TIMEOUT + 1);
    localparam int GAP_W  = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(WB_BEATS - 1);
    localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(TIMEOUT - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYC - 1);

    state_t              state_q;
    logic [CS_W-1:0]     cs_q;
    logic [CS_W-1:0]     last_cs_q;
    logic [RD_AW-1:0]    rd_base_q;
    logic [WB_AW-1:0]    wb_base_q;
    logic [BEAT_W-1:0]   beat_q;
    logic [TMR_W-1:0]    timer_q;
    logic [GAP_W-1:0]    gap_q;
    logic                busy_q;
    logic                done_q;
    logic                err_q;
    logic                dot_load_q;
    logic                wb_en_q;

    logic [RD_AW-1:0]    rd_off;
    logic [WB_AW-1:0]    wb_off;
    logic [WORD_W-1:0]   slice;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cs_q       <= '0;
            last_cs_q  <= '0;
            rd_base_q  <= '0;
            wb_base_q  <= '0;
            beat_q     <= '0;
            timer_q    <= '0;
            gap_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            dot_load_q <= 1'b0;
            wb_en_q    <= 1'b0;
        end else if (abort) begin
            // Cancel wins over every transition, including a start in IDLE.
            state_q    <= ST_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            dot_load_q <= 1'b0;
            wb_en_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        last_cs_q  <= last_cs;
                        rd_base_q  <= rd_base;
                        wb_base_q  <= wb_base;
                        cs_q       <= '0;
                        err_q      <= 1'b0;
                        timer_q    <= '0;
                        busy_q     <= 1'b1;
                        dot_load_q <= 1'b1;
                        state_q    <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (dot_valid) begin
                        beat_q  <= '0;
                        wb_en_q <= 1'b1;
                        state_q <= ST_WB;
                    end else if (timer_q == TMR_LAST) begin
                        // Engine never answered: give up without a done pulse.
                        err_q      <= 1'b1;
                        busy_q     <= 1'b0;
                        dot_load_q <= 1'b0;
                        state_q    <= ST_IDLE;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                ST_WB: begin
                    if (beat_q == BEAT_LAST) begin
                        gap_q      <= '0;
                        wb_en_q    <= 1'b0;
                        dot_load_q <= 1'b0;
                        state_q    <= ST_GAP;
                    end else begin
                        beat_q <= beat_q + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (gap_q == GAP_LAST) begin
                        if (cs_q == last_cs_q) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            cs_q       <= cs_q + 1'b1;
                            timer_q    <= '0;
                            dot_load_q <= 1'b1;
                            state_q    <= ST_LOAD;
                        end
                    end else begin
                        gap_q <= gap_q + 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Abort must silence the write strobe and load in the very cycle it is
    // raised, so those outputs are gated combinationally as well.
    assign busy     = busy_q;
    assign done     = done_q & ~abort;
    assign err      = err_q;
    assign dot_load = dot_load_q & ~abort;
    assign wb_en    = wb_en_q & ~abort;
    assign dot_cs   = cs_q;

    // Address arithmetic deliberately wraps at the address width.
    assign rd_off  = RD_AW'(cs_q) * RD_AW'(RD_STRIDE);
    assign wb_off  = WB_AW'(cs_q) * WB_AW'(WB_BEATS);
    assign wb_addr = wb_base_q + wb_off + WB_AW'(beat_q);

    // dot_addr is a live input, so rd_addr is forced low during reset to
    // keep every output at zero while rst is asserted.
    assign rd_addr = rst ? '0 : (rd_base_q + rd_off + RD_AW'(dot_addr));

    dot_wb_slicer #(
        .ROWS   (DOT_ROWS),
        .BEAT_W (BEAT_W)
    ) u_slicer (
        .dot_q_i   (dot_q),
        .beat_i    (beat_q),
        .wb_data_o (slice)
    );

    assign wb_data = wb_en ? slice : '0;

endmodule
